// File: rtl/ibuf_fwd_sched.sv
// ibuf_fwd_sched: schedules host DMA transfers out of the ingress buffer (ibuf).
//
// The block watches the producer commit pointer. It issues a transfer when a full chunk
// is pending, or when a partial chunk has sat idle for TIMEOUT cycles. A transfer never
// crosses the ibuf wrap. After the DMA engine reports done, the consumer pointer is
// advanced and returned to the producer.
//
// Parameters:
//   BW        ibuf address width (depth 2**BW qwords)
//   CHUNK_QW  maximum qwords per host transfer (1 .. 2**BW)
//   TIMEOUT   idle cycles before a partial chunk is flushed (1 .. 65535)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   host_en           host driver enabled
//   hst_rdy           producer may accept frames
//   activity          producer wrote ibuf this cycle
//   committed_prod    producer commit pointer {wrap, index}
//   committed_cons    consumer pointer returned to the producer {wrap, index}
//   xfer_req          transfer request to the DMA engine
//   xfer_addr         first ibuf qword of the transfer
//   xfer_qw           transfer length in qwords
//   xfer_ack          DMA engine accepted the request
//   xfer_done         DMA engine finished the accepted transfer (pulse)
//   stat_xfers        completed-transfer count
//
// Build option: define IBUF_SCHED_STATS_EN to build the stat_xfers counter;
// otherwise stat_xfers is tied to zero.

module ibuf_fwd_sched #(
   parameter int unsigned BW       = 10,
   parameter int unsigned CHUNK_QW = 32,
   parameter int unsigned TIMEOUT  = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          host_en,
   output logic          hst_rdy,
   input  logic          activity,
   input  logic [BW:0]   committed_prod,
   output logic [BW:0]   committed_cons,
   output logic          xfer_req,
   output logic [BW-1:0] xfer_addr,
   output logic [BW:0]   xfer_qw,
   input  logic          xfer_ack,
   input  logic          xfer_done,
   output logic [31:0]   stat_xfers
);

   localparam int unsigned PW  = BW + 1;
   localparam int unsigned CW  = 16;
   localparam logic [BW:0]   CHUNK   = PW'(CHUNK_QW);
   localparam logic [BW:0]   DEPTH   = PW'(2**BW);
   localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      EVAL,
      REQ,
      BUSY,
      COMMIT
   } state_t;

   state_t        state;
   logic [CW-1:0] idle_cnt;
   logic [BW:0]   pending;
   logic [BW:0]   room;
   logic [BW:0]   len;
   logic          issue;

   // Occupancy, distance to the wrap, and the clipped length of the next transfer.
   always_comb begin
      pending = committed_prod - committed_cons;
      room    = DEPTH - {1'b0, committed_cons[BW-1:0]};
      len     = pending;
      if (CHUNK < len) begin
         len = CHUNK;
      end
      if (room < len) begin
         len = room;
      end
      // An empty buffer never issues, however long it has been idle.
      issue = host_en &&
              ((pending >= CHUNK) || ((pending != '0) && (idle_cnt >= TMO)));
   end

   // Scheduler FSM; every output is a register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         hst_rdy        <= 1'b0;
         committed_cons <= '0;
         xfer_req       <= 1'b0;
         xfer_addr      <= '0;
         xfer_qw        <= '0;
         idle_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (host_en) begin
                  state   <= EVAL;
                  hst_rdy <= 1'b1;
               end
            end

            EVAL: begin
               // The idle counter only runs while the scheduler is waiting for work.
               if (activity || issue) begin
                  idle_cnt <= '0;
               end else if (idle_cnt != CNT_MAX) begin
                  idle_cnt <= idle_cnt + CW'(1);
               end

               if (!host_en) begin
                  state   <= IDLE;
                  hst_rdy <= 1'b0;
               end else if (issue) begin
                  state     <= REQ;
                  xfer_req  <= 1'b1;
                  xfer_addr <= committed_cons[BW-1:0];
                  xfer_qw   <= len;
               end
            end

            // A request or transfer in flight is never aborted by host_en.
            REQ: begin
               if (xfer_ack) begin
                  xfer_req <= 1'b0;
                  state    <= xfer_done ? COMMIT : BUSY;
               end
            end

            BUSY: begin
               if (xfer_done) begin
                  state <= COMMIT;
               end
            end

            COMMIT: begin
               committed_cons <= committed_cons + xfer_qw;
               hst_rdy        <= host_en;
               state          <= host_en ? EVAL : IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef IBUF_SCHED_STATS_EN
   // Completed-transfer counter; wraps naturally at 2**32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_xfers <= '0;
      end else if (state == COMMIT) begin
         stat_xfers <= stat_xfers + 32'd1;
      end
   end
`else
   assign stat_xfers = 32'd0;
`endif

endmodule

// File: tb/tb_ibuf_fwd_sched.sv
module tb_ibuf_fwd_sched;

   localparam int BW    = 10;
   localparam int CHUNK = 32;
   localparam int TMO   = 256;
   localparam int DEPTH = 1 << BW;
   localparam int PMOD  = 2 << BW;

`ifdef IBUF_SCHED_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          host_en;
   logic          hst_rdy;
   logic          activity;
   logic [BW:0]   committed_prod;
   logic [BW:0]   committed_cons;
   logic          xfer_req;
   logic [BW-1:0] xfer_addr;
   logic [BW:0]   xfer_qw;
   logic          xfer_ack;
   logic          xfer_done;
   logic [31:0]   stat_xfers;

   int checks   = 0;
   int failures = 0;
   int exp_cons = 0;

   always #5 clk = ~clk;

   ibuf_fwd_sched #(.BW(BW), .CHUNK_QW(CHUNK), .TIMEOUT(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .host_en        (host_en),
      .hst_rdy        (hst_rdy),
      .activity       (activity),
      .committed_prod (committed_prod),
      .committed_cons (committed_cons),
      .xfer_req       (xfer_req),
      .xfer_addr      (xfer_addr),
      .xfer_qw        (xfer_qw),
      .xfer_ack       (xfer_ack),
      .xfer_done      (xfer_done),
      .stat_xfers     (stat_xfers)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      host_en        = 1'b0;
      activity       = 1'b0;
      committed_prod = '0;
      xfer_ack       = 1'b0;
      xfer_done      = 1'b0;
      exp_cons       = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int min3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

   // Waits for a request, checks it, handshakes it and checks the resulting commit.
   task automatic xfer(input string tag, input int ea, input int eq, input int ack_dly);
      int n;
      n = 0;
      while (xfer_req !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req_seen"}, xfer_req, 1);
      chk({tag, "_addr"}, xfer_addr, ea);
      chk({tag, "_qw"}, xfer_qw, eq);
      repeat (ack_dly) begin
         @(negedge clk);
         chk({tag, "_req_hold"}, xfer_req, 1);
         chk({tag, "_qw_hold"}, xfer_qw, eq);
      end
      xfer_ack = 1'b1;
      @(negedge clk);
      xfer_ack = 1'b0;
      chk({tag, "_req_drop"}, xfer_req, 0);
      xfer_done = 1'b1;
      @(negedge clk);
      xfer_done = 1'b0;
      @(negedge clk);
      exp_cons = (exp_cons + eq) % PMOD;
      chk({tag, "_cons"}, committed_cons, exp_cons);
   endtask

   // Directed per-cycle vectors: inputs applied before an edge, outputs expected after it.
   typedef struct {
      logic he;
      logic act;
      int   prod;
      logic ack;
      logic done;
      logic e_req;
      int   e_addr;
      int   e_qw;
      int   e_cons;
      logic e_rdy;
   } vec_t;

   vec_t vecs[10];

   // Behavioural reference for the random phase.
   typedef enum int {M_IDLE, M_EVAL, M_REQ, M_BUSY, M_COMMIT} mstate_t;
   mstate_t     m_st;
   int          m_cons, m_idle, m_addr, m_qw;
   logic        m_req, m_rdy;
   logic [31:0] m_stat;
   int          p_int;

   task automatic model_reset();
      m_st   = M_IDLE;
      m_cons = 0;
      m_idle = 0;
      m_addr = 0;
      m_qw   = 0;
      m_req  = 1'b0;
      m_rdy  = 1'b0;
      m_stat = 32'd0;
   endtask

   task automatic model_step(input logic he, input logic act, input int prod,
                             input logic ack, input logic done);
      int  pend;
      bit  go;
      case (m_st)
         M_IDLE: if (he) begin m_st = M_EVAL; m_rdy = 1'b1; end
         M_EVAL: begin
            pend = (prod - m_cons + PMOD) % PMOD;
            go   = he && (pend >= CHUNK || (pend > 0 && m_idle >= TMO));
            if (act || go) m_idle = 0;
            else if (m_idle < 65535) m_idle = m_idle + 1;
            if (!he) begin
               m_st  = M_IDLE;
               m_rdy = 1'b0;
            end else if (go) begin
               m_st   = M_REQ;
               m_req  = 1'b1;
               m_addr = m_cons % DEPTH;
               m_qw   = min3(pend, CHUNK, DEPTH - (m_cons % DEPTH));
            end
         end
         M_REQ: if (ack) begin m_req = 1'b0; m_st = done ? M_COMMIT : M_BUSY; end
         M_BUSY: if (done) m_st = M_COMMIT;
         default: begin
            m_cons = (m_cons + m_qw) % PMOD;
            m_stat = m_stat + 32'(STATS);
            m_rdy  = he;
            m_st   = he ? M_EVAL : M_IDLE;
         end
      endcase
   endtask

   initial begin
      int n;
      int inc;
      int space;

      vecs[0] = '{1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 40, 1'b0, 1'b0, 1'b1, 0, 32,  0, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 40, 1'b0, 1'b0, 1'b1, 0, 32,  0, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 40, 1'b1, 1'b0, 1'b0, 0, 32,  0, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 40, 1'b0, 1'b0, 1'b0, 0, 32,  0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 40, 1'b0, 1'b1, 1'b0, 0, 32,  0, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 40, 1'b0, 1'b0, 1'b0, 0, 32, 32, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 40, 1'b1, 1'b1, 1'b0, 0, 32, 32, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b0, 0, 32, 32, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 40, 1'b0, 1'b0, 1'b0, 0, 32, 32, 1'b1};

      // Reset values while rst is held.
      rst = 1'b1;
      host_en = 1'b0; activity = 1'b0; committed_prod = '0;
      xfer_ack = 1'b0; xfer_done = 1'b0;
      @(negedge clk);
      chk("rst_req", xfer_req, 0);
      chk("rst_addr", xfer_addr, 0);
      chk("rst_qw", xfer_qw, 0);
      chk("rst_cons", committed_cons, 0);
      chk("rst_rdy", hst_rdy, 0);
      chk("rst_stat", stat_xfers, 0);

      // Full chunk, table driven.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         host_en        = vecs[i].he;
         activity       = vecs[i].act;
         committed_prod = (BW + 1)'(vecs[i].prod);
         xfer_ack       = vecs[i].ack;
         xfer_done      = vecs[i].done;
         @(negedge clk);
         chk($sformatf("vec%0d_req", i), xfer_req, vecs[i].e_req);
         chk($sformatf("vec%0d_addr", i), xfer_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_qw", i), xfer_qw, vecs[i].e_qw);
         chk($sformatf("vec%0d_cons", i), committed_cons, vecs[i].e_cons);
         chk($sformatf("vec%0d_rdy", i), hst_rdy, vecs[i].e_rdy);
      end

      // Partial flush after exactly TIMEOUT idle cycles, then same-cycle ack+done.
      do_reset();
      host_en = 1'b1;
      committed_prod = (BW + 1)'(5);
      n = 0;
      while (xfer_req !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("flush_latency", n, 1 + TMO + 1);
      chk("flush_qw", xfer_qw, 5);
      chk("flush_addr", xfer_addr, 0);
      xfer_ack = 1'b1; xfer_done = 1'b1;
      @(negedge clk);
      xfer_ack = 1'b0; xfer_done = 1'b0;
      chk("ackdone_req", xfer_req, 0);
      chk("ackdone_cons_before", committed_cons, 0);
      @(negedge clk);
      chk("ackdone_cons", committed_cons, 5);
      chk("ackdone_stat", stat_xfers, STATS);
      chk("ackdone_rdy", hst_rdy, 1);

      // Walk the consumer to 1020, then clip at the wrap.
      do_reset();
      host_en = 1'b1;
      committed_prod = (BW + 1)'(1020);
      for (int k = 0; k < 31; k++) xfer($sformatf("walk%0d", k), 32 * k, 32, k % 2);
      xfer("walk_tail", 992, 28, 0);
      n = 0;
      repeat (300) begin
         @(negedge clk);
         if (xfer_req === 1'b1) n++;
      end
      chk("empty_no_issue", n, 0);
      committed_prod = (BW + 1)'(1060);
      activity = 1'b1;
      @(negedge clk);
      activity = 1'b0;
      xfer("wrap_clip", 1020, 4, 0);
      xfer("wrap_after", 0, 32, 1);
      chk("wrap_stat", stat_xfers, 34 * STATS);

      // Host disable while busy: transfer still commits, then stays idle.
      committed_prod = (BW + 1)'(1100);
      n = 0;
      while (xfer_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("dis_req", xfer_req, 1);
      chk("dis_addr", xfer_addr, 32);
      chk("dis_qw", xfer_qw, 32);
      xfer_ack = 1'b1;
      @(negedge clk);
      xfer_ack = 1'b0;
      host_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("dis_busy_req", xfer_req, 0);
      chk("dis_busy_cons", committed_cons, 1056);
      xfer_done = 1'b1;
      @(negedge clk);
      xfer_done = 1'b0;
      @(negedge clk);
      chk("dis_cons", committed_cons, 1088);
      chk("dis_rdy", hst_rdy, 0);
      committed_prod = (BW + 1)'(1200);
      n = 0;
      repeat (50) begin
         @(negedge clk);
         if (xfer_req === 1'b1 || hst_rdy === 1'b1) n++;
      end
      chk("dis_quiet", n, 0);

      // Asynchronous reset while a request is outstanding.
      host_en = 1'b1;
      n = 0;
      while (xfer_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("arst_req_before", xfer_req, 1);
      #2 rst = 1'b1;
      host_en = 1'b0;
      committed_prod = '0;
      #1;
      chk("arst_req", xfer_req, 0);
      chk("arst_cons", committed_cons, 0);
      chk("arst_qw", xfer_qw, 0);
      chk("arst_rdy", hst_rdy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_after_req", xfer_req, 0);
      chk("arst_after_cons", committed_cons, 0);

      // Randomized run against the reference model.
      do_reset();
      model_reset();
      p_int = 0;
      host_en = 1'b1;
      model_step(host_en, activity, p_int, xfer_ack, xfer_done);
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         chk("rnd_req", xfer_req, m_req);
         chk("rnd_addr", xfer_addr, m_addr);
         chk("rnd_qw", xfer_qw, m_qw);
         chk("rnd_cons", committed_cons, m_cons);
         chk("rnd_rdy", hst_rdy, m_rdy);
         chk("rnd_stat", stat_xfers, m_stat);
         if ($urandom_range(0, 99) == 0) host_en = ~host_en;
         inc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
         if ($urandom_range(0, 199) == 0) inc = int'($urandom_range(20, 60));
         if ((cyc / 500) % 3 == 2) inc = 0;
         space = DEPTH - ((p_int - m_cons + PMOD) % PMOD);
         if (inc > space) inc = space;
         p_int          = (p_int + inc) % PMOD;
         committed_prod = (BW + 1)'(p_int);
         activity       = (inc != 0);
         xfer_ack       = ($urandom_range(0, 2) == 0);
         xfer_done      = ($urandom_range(0, 3) == 0);
         model_step(host_en, activity, p_int, xfer_ack, xfer_done);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ibuf_fwd_sched.md
IBUF_FWD_SCHED -- requirements
Module: ibuf_fwd_sched

Interface
REQ-001 SHALL have parameter BW, default 10: ibuf address width; ibuf depth is 2**BW qwords.
REQ-002 SHALL have parameter CHUNK_QW, default 32: maximum qwords per host transfer, range 1 to 2**BW.
REQ-003 SHALL have parameter TIMEOUT, default 256: idle cycles before a partial chunk is flushed, range 1 to 65535.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port host_en  input  1  host driver enabled.
REQ-007 SHALL have port hst_rdy  output  1  permits the producer to accept frames.
REQ-008 SHALL have port activity  input  1  producer wrote ibuf this cycle.
REQ-009 SHALL have port committed_prod  input  BW+1  producer commit pointer (wrap bit plus index).
REQ-010 SHALL have port committed_cons  output  BW+1  consumer pointer returned to the producer.
REQ-011 SHALL have port xfer_req  output  1  transfer request to the DMA engine.
REQ-012 SHALL have port xfer_addr  output  BW  first ibuf qword of the transfer.
REQ-013 SHALL have port xfer_qw  output  BW+1  transfer length in qwords.
REQ-014 SHALL have port xfer_ack  input  1  DMA engine accepted the request.
REQ-015 SHALL have port xfer_done  input  1  one-cycle pulse: DMA engine finished the accepted transfer.
REQ-016 SHALL have port stat_xfers  output  32  completed-transfer count.

Function
REQ-017 SHALL compute pending = (committed_prod - committed_cons) mod 2**(BW+1); pending = 2**BW means full.
REQ-018 SHALL implement states IDLE, EVAL, REQ, BUSY and COMMIT.
REQ-019 IDLE: hst_rdy=0; go to EVAL when host_en is 1.
REQ-020 EVAL: hst_rdy=1; a 16-bit idle counter clears when activity=1 or a transfer issues, otherwise increments and saturates.
REQ-021 EVAL: issue when pending >= CHUNK_QW, or when pending > 0 and idle counter >= TIMEOUT; then go to REQ.
REQ-022 On issue, xfer_qw SHALL be min(pending, CHUNK_QW, 2**BW - committed_cons[BW-1:0]); the transfer never crosses the ibuf wrap.
REQ-023 On issue, xfer_addr SHALL be committed_cons[BW-1:0].
REQ-024 REQ: xfer_req=1, with xfer_addr and xfer_qw stable until the cycle xfer_ack=1; then go to BUSY, xfer_req=0 in the next cycle.
REQ-025 If xfer_ack and xfer_done are both 1 in the same REQ cycle, SHALL go directly to COMMIT.
REQ-026 BUSY: wait for xfer_done=1, then go to COMMIT.
REQ-027 COMMIT, one cycle: committed_cons SHALL be set to committed_cons + xfer_qw (mod 2**(BW+1)).
REQ-028 COMMIT next state: EVAL if host_en=1, else IDLE.
REQ-029 Latency: a full chunk present in EVAL SHALL raise xfer_req on the next cycle.
REQ-030 In EVAL, host_en=0 SHALL move the block to IDLE next cycle; in REQ or BUSY it SHALL not abort — the transfer completes, then IDLE.
REQ-031 xfer_done outside REQ and BUSY SHALL be ignored.
REQ-032 pending = 0 SHALL never issue, regardless of the idle counter.

Reset
REQ-033 While rst=1: state=IDLE, committed_cons=0, hst_rdy=0, xfer_req=0, xfer_addr=0, xfer_qw=0, idle counter=0, stat_xfers=0.
REQ-034 rst mid-transfer SHALL drop xfer_req immediately and discard the in-flight length; no commit occurs.

Configuration
REQ-035 With IBUF_SCHED_STATS_EN defined, stat_xfers SHALL increment in each COMMIT cycle and wrap at 2**32.
REQ-036 Without IBUF_SCHED_STATS_EN, stat_xfers SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-037 Full chunk: BW=10, CHUNK_QW=32, prod 0->40 -> xfer_req with addr 0, qw 32; after done, cons=32.
REQ-038 Partial flush: BW=10, CHUNK_QW=32, TIMEOUT=256, prod=5, activity held 0 -> xfer_req at idle count 256, qw=5.
REQ-039 Wrap clip: cons=1020, prod=1060 (mod 2048) -> qw=4, then addr 0, qw=32.
REQ-040 Host disable: host_en dropped in BUSY -> done still commits, hst_rdy=0, no further xfer_req.
REQ-041 Same-cycle ack+done -> COMMIT next cycle; stat_xfers +1 with IBUF_SCHED_STATS_EN, 0 without.
REQ-042 Async rst asserted in REQ -> xfer_req=0 before the next clock edge; cons=0.
